// File: rtl/dmem_responder_if.sv
// dmem_responder_if: memory-stage request/response bundle between the pipeline (master) and the data memory (slave)
interface dmem_responder_if;
  logic        MemReqM;
  logic        MemWriteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        MemStallM;
  logic        MemDoneM;
  logic        MisalignM;
  modport master (
    output MemReqM, MemWriteM, ALUOutM, WriteDataM,
    input  ReadDataM, MemStallM, MemDoneM, MisalignM
  );
  modport slave (
    input  MemReqM, MemWriteM, ALUOutM, WriteDataM,
    output ReadDataM, MemStallM, MemDoneM, MisalignM
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency word data memory with stall/done handshake; define DMEM_MISALIGN_CHECK_EN to suppress and flag misaligned accesses
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic reset,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t        state;
  logic [3:0]    cnt;
  logic          wr_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [31:0]   mem [DEPTH];
  logic          fire;
  logic          ok;
  assign fire = state == WAIT && cnt == 4'd0;
  assign bus.MemStallM = (state == IDLE && bus.MemReqM) || state == WAIT;
`ifdef DMEM_MISALIGN_CHECK_EN
  logic mis_q;
  assign ok = !mis_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) mis_q <= 1'b0;
    else if (state == IDLE && bus.MemReqM) mis_q <= |bus.ALUOutM[1:0];
`else
  assign ok = 1'b1;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      wr_q          <= 1'b0;
      idx_q         <= '0;
      wdata_q       <= 32'd0;
      bus.ReadDataM <= 32'd0;
      bus.MemDoneM  <= 1'b0;
      bus.MisalignM <= 1'b0;
    end else begin
      bus.MemDoneM  <= fire;
      bus.MisalignM <= fire && !ok;
      if (state == IDLE && bus.MemReqM) begin
        wr_q    <= bus.MemWriteM;
        idx_q   <= bus.ALUOutM[AW+1:2];
        wdata_q <= bus.WriteDataM;
        cnt     <= 4'(LATENCY - 1);
        state   <= WAIT;
      end else if (state == WAIT) begin
        cnt   <= fire ? cnt : cnt - 4'd1;
        state <= fire ? DONE : WAIT;
        if (fire && !wr_q && ok) bus.ReadDataM <= mem[idx_q];
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
  // array is not reset; a reset during WAIT leaves state IDLE so no write can fire
  always_ff @(posedge clk)
    if (fire && wr_q && ok) mem[idx_q] <= wdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed stimulus against a cycle-level reference model of the data memory responder
module tb_dmem_responder;
  localparam int DEPTH = 64;
  localparam int LAT   = 2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int nvec = 0;
  int nerr = 0;
  int ndone = 0;
  bit chk_en = 1'b0;
  dmem_responder_if bus ();
  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  logic [31:0] mm [DEPTH];
  bit          kn [DEPTH];
  int          ph = 0;
  bit          cw = 1'b0;
  bit          cmis = 1'b0;
  logic [31:0] ca = 32'd0;
  logic [31:0] cd = 32'd0;
  logic [31:0] mrd = 32'd0;
  bit          rkn = 1'b1;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // reference: an accepted request occupies LATENCY+2 cycles, the access lands at the end of the last stall cycle
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph = 0;
      mrd = 32'd0;
      rkn = 1'b1;
      cmis = 1'b0;
    end else if (ph == 0) begin
      if (bus.MemReqM) begin
        cw = bus.MemWriteM;
        ca = bus.ALUOutM;
        cd = bus.WriteDataM;
        ph = 1;
      end
    end else if (ph == LAT + 1) begin
      ph = 0;
    end else begin
      if (ph == LAT) begin
        int i;
        i = int'((ca >> 2) % DEPTH);
`ifdef DMEM_MISALIGN_CHECK_EN
        cmis = ca[1:0] != 2'b00;
`else
        cmis = 1'b0;
`endif
        if (!cmis) begin
          if (cw) begin
            mm[i] = cd;
            kn[i] = 1'b1;
          end else begin
            mrd = mm[i];
            rkn = kn[i];
          end
        end
      end
      ph++;
    end
  end

  always @(negedge clk) begin
    if (bus.MemDoneM) ndone++;
    if (chk_en) begin
      check("stall", {31'd0, bus.MemStallM}, {31'd0, ph == 0 ? bus.MemReqM : ph <= LAT});
      check("done", {31'd0, bus.MemDoneM}, {31'd0, ph == LAT + 1});
      check("misalign", {31'd0, bus.MisalignM}, {31'd0, ph == LAT + 1 && cmis});
      if (rkn) check("rdata", bus.ReadDataM, mrd);
    end
  end

  task automatic acc(input bit w, input logic [31:0] a, input logic [31:0] d, input string n);
    int lat;
    int nst;
    @(posedge clk); #1;
    bus.MemReqM = 1'b1;
    bus.MemWriteM = w;
    bus.ALUOutM = a;
    bus.WriteDataM = d;
    #1 nst = bus.MemStallM ? 1 : 0;
    @(posedge clk); #1;
    bus.MemReqM = 1'b0;
    bus.MemWriteM = ~w;
    bus.ALUOutM = a ^ 32'h30;
    bus.WriteDataM = ~d;
    lat = 99;
    for (int i = 1; i < 20; i++) begin
      if (bus.MemDoneM) begin
        lat = i;
        break;
      end
      if (bus.MemStallM) nst++;
      @(posedge clk); #1;
    end
    check({n, "_lat"}, lat, 3);
    check({n, "_nstall"}, nst, 3);
  endtask

  initial begin
    int nb, nd, d1, d2;
    bus.MemReqM = 1'b0;
    bus.MemWriteM = 1'b0;
    bus.ALUOutM = 32'd0;
    bus.WriteDataM = 32'd0;
    for (int i = 0; i < DEPTH; i++) kn[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    bus.MemReqM = 1'b1;
    #1 check("rst_stall_req", {31'd0, bus.MemStallM}, 32'd1);
    bus.MemReqM = 1'b0;
    #1 check("rst_stall", {31'd0, bus.MemStallM}, 32'd0);
    check("rst_rdata", bus.ReadDataM, 32'd0);
    check("rst_done", {31'd0, bus.MemDoneM}, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    acc(1'b1, 32'h10, 32'h12345678, "st10");
    acc(1'b0, 32'h10, 32'h0, "ld10");
    check("ld10_data", bus.ReadDataM, 32'h12345678);
    acc(1'b1, 32'h20, 32'h0BADBEEF, "st20");
    acc(1'b0, 32'h10, 32'h0, "ld10_chg");
    check("ld_addr_held", bus.ReadDataM, 32'h12345678);
    acc(1'b1, 32'h100, 32'hCAFEF00D, "st100");
    acc(1'b0, 32'h0, 32'h0, "ld0");
    check("wrap", bus.ReadDataM, 32'hCAFEF00D);
    acc(1'b1, 32'h8, 32'h11111111, "st8");
    @(posedge clk); #1;
    bus.MemReqM = 1'b1;
    bus.MemWriteM = 1'b1;
    bus.ALUOutM = 32'h8;
    bus.WriteDataM = 32'hAAAA5555;
    nb = ndone;
    @(posedge clk); #1 bus.MemReqM = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    #2 reset = 1'b1;
    check("abort_rdata", bus.ReadDataM, 32'd0);
    repeat (6) @(posedge clk);
    #1 check("abort_nodone", ndone - nb, 32'd0);
    acc(1'b0, 32'h8, 32'h0, "ld8");
    check("abort_kept", bus.ReadDataM, 32'h11111111);
    @(posedge clk); #1;
    bus.MemReqM = 1'b1;
    bus.MemWriteM = 1'b0;
    bus.ALUOutM = 32'h100;
    nd = 0;
    d1 = -1;
    d2 = -1;
    for (int i = 0; i < 14; i++) begin
      if (i == 5) bus.MemReqM = 1'b0;
      if (bus.MemDoneM) begin
        if (nd == 0) d1 = i;
        else d2 = i;
        nd++;
      end
      @(posedge clk); #1;
    end
    check("b2b_count", nd, 2);
    check("b2b_first", d1, 3);
    check("b2b_second", d2, 7);
    acc(1'b1, 32'h12, 32'h5A5A5A5A, "st12");
`ifdef DMEM_MISALIGN_CHECK_EN
    check("mis_flag", {31'd0, bus.MisalignM}, 32'd1);
    acc(1'b0, 32'h10, 32'h0, "ld10_mis");
    check("mis_nowrite", bus.ReadDataM, 32'h12345678);
`else
    check("mis_flag", {31'd0, bus.MisalignM}, 32'd0);
    acc(1'b0, 32'h10, 32'h0, "ld10_mis");
    check("mis_write", bus.ReadDataM, 32'h5A5A5A5A);
`endif
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit data-memory words; power of two, 4..1024.
REQ-002 Parameter LATENCY, default 2: WAIT cycles per access; range 1..15.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 MemReqM  input  1  memory-stage access request (load or store).
REQ-006 MemWriteM  input  1  1 = store, 0 = load; sampled with MemReqM.
REQ-007 ALUOutM  input  32  byte address of the access.
REQ-008 WriteDataM  input  32  store data.
REQ-009 ReadDataM  output  32  registered load data.
REQ-010 MemStallM  output  1  stall request to the hazard unit; pipeline holds M and earlier stages while 1.
REQ-011 MemDoneM  output  1  one-cycle completion pulse.
REQ-012 MisalignM  output  1  misaligned-access flag; see Configuration.

Function
REQ-013 FSM states IDLE, WAIT and DONE; 4-bit down-counter cnt.
REQ-014 IDLE, MemReqM=1: capture ALUOutM, MemWriteM, WriteDataM; load cnt=LATENCY-1; go to WAIT.
REQ-015 IDLE, MemReqM=0: remain in IDLE; no array access.
REQ-016 WAIT, cnt!=0: decrement cnt; remain in WAIT; captured request held; inputs ignored.
REQ-017 WAIT, cnt==0: at that edge perform the access with captured values; go to DONE.
REQ-018 Store: array[addr[log2(DEPTH)+1:2]] <= captured data; ReadDataM unchanged.
REQ-019 Load: ReadDataM <= array[addr[log2(DEPTH)+1:2]]; ReadDataM then held until the next completed load.
REQ-020 Address bits above log2(DEPTH)+1 ignored; addresses wrap modulo 4*DEPTH bytes.
REQ-021 DONE: MemDoneM=1 and MemStallM=0 for exactly one cycle; MemReqM seen in DONE is the already-served request and is ignored; unconditionally go to IDLE.
REQ-022 MemStallM = (state==IDLE & MemReqM) | (state==WAIT), combinational; it rises in the same cycle as a new request.
REQ-023 Timing: request in cycle 0 -> MemStallM high cycles 0..LATENCY -> DONE and valid ReadDataM in cycle LATENCY+1.
REQ-024 Back-to-back requests: a request present in the cycle after DONE is accepted from IDLE per REQ-014; minimum spacing LATENCY+2 cycles.
REQ-025 MemWriteM, ALUOutM and WriteDataM changing during WAIT or DONE have no effect on the access in progress.

Reset
REQ-026 reset=0 forces, asynchronously: state=IDLE, cnt=0, ReadDataM=0, MemDoneM=0, MisalignM=0, captured request cleared.
REQ-027 MemStallM reads 0 during reset unless MemReqM=1 (per REQ-022).
REQ-028 Reset mid-access (WAIT): pending store discarded, array unchanged, no MemDoneM pulse.
REQ-029 Array contents are not reset.
REQ-030 After reset deasserts, the first rising edge with MemReqM=1 starts an access per REQ-014.

Configuration
REQ-031 Macro DMEM_MISALIGN_CHECK_EN defined: captured addr[1:0]!=0 suppresses the array write/read (ReadDataM unchanged); MisalignM=1 during the DONE cycle only; timing per REQ-023.
REQ-032 Macro absent: addr[1:0] ignored (access proceeds at the word index); MisalignM tied to 0.

Verification
REQ-033 LATENCY=2: store 0x12345678 @0x10, then load @0x10 -> MemStallM high 3 cycles each, MemDoneM in cycle 3, ReadDataM=0x12345678.
REQ-034 DEPTH=64: store 0xCAFEF00D @0x100, load @0x000 -> ReadDataM=0xCAFEF00D (wrap).
REQ-035 Load issued, ALUOutM changed to 0x20 during WAIT -> data from the original address returned.
REQ-036 reset=0 in WAIT of store 0xAAAA5555 @0x8, then load @0x8 -> prior contents returned, no MemDoneM for the aborted store.
REQ-037 MemReqM held high through DONE and next cycle -> exactly two accesses, MemDoneM pulses 4 cycles apart (LATENCY=2).
REQ-038 With DMEM_MISALIGN_CHECK_EN: store @0x12 -> MisalignM=1 in DONE only, array unchanged; without macro -> word 4 written, MisalignM=0.
